// File: rtl/rtype_sequencer_pkg.sv
// Shared definitions for the R-type sequencer: operation encodings,
// sequencer state encoding and register-index width.
package rtype_sequencer_pkg;

    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        F_ADD = 3'd0,
        F_SUB = 3'd1,
        F_AND = 3'd2,
        F_OR  = 3'd3,
        F_XOR = 3'd4,
        F_SLT = 3'd5,
        F_SLL = 3'd6,
        F_SRL = 3'd7
    } funct_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/rtype_alu.sv
// Combinational R-type ALU: arithmetic wraps, SLT is signed, shifts use
// only the low clog2(W) bits of b.
module rtype_alu
    import rtype_sequencer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  funct_t       funct,
    output logic [W-1:0] y
);

    localparam int SH_W = $clog2(W);

    logic signed [W-1:0] a_s;
    logic signed [W-1:0] b_s;
    logic [SH_W-1:0]     shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SH_W-1:0];

    // Operation select
    always_comb begin
        y = '0;
        case (funct)
            F_ADD: y = a + b;
            F_SUB: y = a - b;
            F_AND: y = a & b;
            F_OR:  y = a | b;
            F_XOR: y = a ^ b;
            F_SLT: y = {{(W-1){1'b0}}, (a_s < b_s)};
            F_SLL: y = a << shamt;
            F_SRL: y = a >> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rtype_sequencer.sv
// Four-state sequencer that reads two registers, runs one ALU operation
// and writes the result back through the register-file write port.
module rtype_sequencer
    import rtype_sequencer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic [REG_W-1:0] Read1,
    output logic [REG_W-1:0] Read2,
    input  logic [W-1:0]     Data1,
    input  logic [W-1:0]     Data2,
    output logic [REG_W-1:0] WriteReg,
    output logic [W-1:0]     WriteData,
    output logic             RegWrite
);

    state_t           state;
    funct_t           funct_q;
    logic [REG_W-1:0] rd_q;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     alu_y;

    rtype_alu #(.W(W)) u_alu (
        .a     (a),
        .b     (b),
        .funct (funct_q),
        .y     (alu_y)
    );

    assign busy      = (state != S_IDLE);
    assign WriteData = result;

    // Sequencer FSM; Read1/Read2 double as the latched source indices and
    // only change when a new start is accepted, so they hold between ops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            funct_q  <= F_ADD;
            Read1    <= '0;
            Read2    <= '0;
            rd_q     <= '0;
            a        <= '0;
            b        <= '0;
            result   <= '0;
            WriteReg <= '0;
            RegWrite <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        funct_q <= funct_t'(funct);
                        Read1   <= rs1;
                        Read2   <= rs2;
                        rd_q    <= rd;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    a     <= Data1;
                    b     <= Data2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result   <= alu_y;
                    WriteReg <= rd_q;
                    RegWrite <= (rd_q != '0);
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    RegWrite <= 1'b0;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Directed bench for rtype_sequencer with a behavioural register file.
module tb_rtype_sequencer;

    localparam int W = 32;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [2:0]    funct;
    logic [4:0]    rs1, rs2, rd;
    logic          busy, done, RegWrite;
    logic [W-1:0]  result, Data1, Data2, WriteData;
    logic [4:0]    Read1, Read2, WriteReg;

    logic [W-1:0]  rf [0:31];
    logic          ld_en;
    logic [4:0]    ld_addr;
    logic [W-1:0]  ld_data;

    int vectors = 0;
    int errors  = 0;

    rtype_sequencer #(.W(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .funct     (funct),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .Read1     (Read1),
        .Read2     (Read2),
        .Data1     (Data1),
        .Data2     (Data2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file: combinational read, x0 reads zero, write on rising edge
    assign Data1 = (Read1 == 5'd0) ? '0 : rf[Read1];
    assign Data2 = (Read2 == 5'd0) ? '0 : rf[Read2];
    always @(posedge clock) begin
        if (ld_en) rf[ld_addr] <= ld_data;
        else if (RegWrite && WriteReg != 5'd0) rf[WriteReg] <= WriteData;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int addr, input logic [W-1:0] data);
        ld_en = 1'b1; ld_addr = addr[4:0]; ld_data = data;
        tick;
        ld_en = 1'b0;
    endtask

    // Drive one operation, scramble the inputs after acceptance, then wait
    // (bounded) for done; returns edges from acceptance to done.
    task automatic issue(input logic [2:0] f, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, output int cycles);
        start = 1'b1; funct = f; rs1 = s1; rs2 = s2; rd = d;
        tick;
        start = 1'b0; funct = ~f; rs1 = ~s1; rs2 = ~s2; rd = ~d;
        cycles = 1;
        while (!done && cycles < 12) begin
            tick;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; funct = '0; rs1 = '0; rs2 = '0; rd = '0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 32; i++) load(i, '0);
        vectors++;
        if ({busy, done, RegWrite} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: busy/done/RegWrite=%b required 000", {busy, done, RegWrite});
        end
        vectors++;
        if (result !== '0 || Read1 !== '0 || Read2 !== '0 || WriteReg !== '0) begin
            errors++; $display("FAIL reset_regs: result=%h Read1=%0d Read2=%0d WriteReg=%0d required all 0",
                               result, Read1, Read2, WriteReg);
        end
        reset_n = 1'b1;
        load(10, 32'd15);
        load(7, 32'd5);
        load(13, 32'hFFFF_FF24);
        load(14, 32'hFFFF_FFFF);
    endtask

    task automatic test_add_timing;
        start = 1'b1; funct = 3'd0; rs1 = 5'd10; rs2 = 5'd7; rd = 5'd3;
        tick;
        start = 1'b0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd9; funct = 3'd4;
        vectors++;
        if (busy !== 1'b1 || Read1 !== 5'd10 || Read2 !== 5'd7 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL add_read: busy=%b Read1=%0d Read2=%0d RegWrite=%b required 1 10 7 0",
                               busy, Read1, Read2, RegWrite);
        end
        tick;
        vectors++;
        if (RegWrite !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL add_exec: RegWrite=%b done=%b required 0 0", RegWrite, done);
        end
        tick;
        vectors++;
        if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'd20 || done !== 1'b0) begin
            errors++; $display("FAIL add_write: RegWrite=%b WriteReg=%0d WriteData=%0d done=%b required 1 3 20 0",
                               RegWrite, WriteReg, WriteData, done);
        end
        tick;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'd20 || rf[3] !== 32'd20 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL add_done: done=%b busy=%b result=%0d x3=%0d RegWrite=%b required 1 0 20 20 0",
                               done, busy, result, rf[3], RegWrite);
        end
        tick;
        vectors++;
        if (done !== 1'b0 || result !== 32'd20 || WriteReg !== 5'd3 || Read1 !== 5'd10) begin
            errors++; $display("FAIL add_hold: done=%b result=%0d WriteReg=%0d Read1=%0d required 0 20 3 10",
                               done, result, WriteReg, Read1);
        end
    endtask

    task automatic test_alu_ops;
        int c;
        issue(3'd1, 5'd7, 5'd10, 5'd4, c);
        vectors++;
        if (c !== 4 || result !== 32'hFFFF_FFF6 || rf[4] !== 32'hFFFF_FFF6) begin
            errors++; $display("FAIL sub: cycles=%0d result=%h x4=%h required 4 fffffff6 fffffff6", c, result, rf[4]);
        end
        tick;
        issue(3'd5, 5'd4, 5'd7, 5'd5, c);
        vectors++;
        if (result !== 32'd1 || rf[5] !== 32'd1) begin
            errors++; $display("FAIL slt_neg: result=%h x5=%h required 1", result, rf[5]);
        end
        tick;
        issue(3'd5, 5'd7, 5'd7, 5'd15, c);
        vectors++;
        if (rf[15] !== 32'd0) begin
            errors++; $display("FAIL slt_equal: x15=%h required 0", rf[15]);
        end
        tick;
        issue(3'd6, 5'd7, 5'd10, 5'd6, c);
        vectors++;
        if (rf[6] !== 32'h0002_8000) begin
            errors++; $display("FAIL sll: x6=%h required 00028000", rf[6]);
        end
        tick;
        issue(3'd6, 5'd10, 5'd13, 5'd16, c);
        vectors++;
        if (rf[16] !== 32'h0000_00F0) begin
            errors++; $display("FAIL sll_highbits: x16=%h required 000000f0", rf[16]);
        end
        tick;
        issue(3'd7, 5'd6, 5'd7, 5'd17, c);
        vectors++;
        if (rf[17] !== 32'h0000_1400) begin
            errors++; $display("FAIL srl: x17=%h required 00001400", rf[17]);
        end
        tick;
        issue(3'd0, 5'd14, 5'd10, 5'd18, c);
        vectors++;
        if (rf[18] !== 32'd14) begin
            errors++; $display("FAIL add_wrap: x18=%h required e", rf[18]);
        end
        tick;
        issue(3'd2, 5'd10, 5'd13, 5'd19, c);
        vectors++;
        if (rf[19] !== 32'd4) begin
            errors++; $display("FAIL and: x19=%h required 4", rf[19]);
        end
        tick;
        issue(3'd0, 5'd3, 5'd3, 5'd3, c);
        vectors++;
        if (rf[3] !== 32'd40 || result !== 32'd40) begin
            errors++; $display("FAIL rd_eq_rs: x3=%0d result=%0d required 40 40", rf[3], result);
        end
        tick;
    endtask

    task automatic test_rd_zero;
        logic seen;
        int   c;
        seen = 1'b0;
        start = 1'b1; funct = 3'd4; rs1 = 5'd10; rs2 = 5'd7; rd = 5'd0;
        tick;
        start = 1'b0;
        c = 1;
        while (!done && c < 12) begin
            if (RegWrite) seen = 1'b1;
            tick;
            c++;
        end
        vectors++;
        if (seen !== 1'b0 || c !== 4 || result !== 32'd10 || rf[0] !== 32'd0) begin
            errors++; $display("FAIL rd_zero: RegWrite_seen=%b cycles=%0d result=%0d x0=%0d required 0 4 10 0",
                               seen, c, result, rf[0]);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int c;
        start = 1'b1; funct = 3'd3; rs1 = 5'd10; rs2 = 5'd7; rd = 5'd8;
        tick;
        start = 1'b1; funct = 3'd0; rs1 = 5'd6; rs2 = 5'd6; rd = 5'd9;
        tick;
        start = 1'b0;
        c = 2;
        while (!done && c < 12) begin
            tick;
            c++;
        end
        vectors++;
        if (c !== 4 || result !== 32'd15 || rf[8] !== 32'd15 || rf[9] !== 32'd0) begin
            errors++; $display("FAIL busy_ignore: cycles=%0d result=%0d x8=%0d x9=%0d required 4 15 15 0",
                               c, result, rf[8], rf[9]);
        end
        start = 1'b1; funct = 3'd1; rs1 = 5'd10; rs2 = 5'd8; rd = 5'd20;
        tick;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || Read1 !== 5'd10 || Read2 !== 5'd8) begin
            errors++; $display("FAIL done_cycle_start: busy=%b Read1=%0d Read2=%0d required 1 10 8", busy, Read1, Read2);
        end
        c = 1;
        while (!done && c < 12) begin
            tick;
            c++;
        end
        vectors++;
        if (c !== 4 || rf[20] !== 32'd0) begin
            errors++; $display("FAIL done_cycle_op: cycles=%0d x20=%0d required 4 0", c, rf[20]);
        end
        tick;
    endtask

    task automatic test_reset_in_write;
        int c;
        start = 1'b1; funct = 3'd2; rs1 = 5'd10; rs2 = 5'd7; rd = 5'd11;
        tick;
        start = 1'b0;
        tick;
        tick;
        vectors++;
        if (RegWrite !== 1'b1) begin
            errors++; $display("FAIL pre_reset_write: RegWrite=%b required 1", RegWrite);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (RegWrite !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 || WriteReg !== '0) begin
            errors++; $display("FAIL reset_abort: RegWrite=%b busy=%b done=%b result=%h WriteReg=%0d required 0 0 0 0 0",
                               RegWrite, busy, done, result, WriteReg);
        end
        tick;
        reset_n = 1'b1;
        tick;
        vectors++;
        if (rf[11] !== 32'd0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_no_write: x11=%h done=%b required 0 0", rf[11], done);
        end
        issue(3'd0, 5'd10, 5'd7, 5'd12, c);
        vectors++;
        if (c !== 4 || rf[12] !== 32'd20) begin
            errors++; $display("FAIL post_reset_op: cycles=%0d x12=%0d required 4 20", c, rf[12]);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_add_timing;
        test_alu_ops;
        test_rd_zero;
        test_back_to_back;
        test_reset_in_write;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
